// File: rtl/dac_spi_receiver.sv
// SPI responder modelling a double-buffered dual 12-bit DAC: oversampled SPI decode
// into per-channel input registers, transferred to outputs on a latchn falling edge.
module dac_spi_receiver #(
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_csn,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  input  logic                 spi_latchn,
  output logic [DATA_BITS-1:0] dac_a,
  output logic [DATA_BITS-1:0] dac_b,
  output logic                 gain_a,
  output logic                 gain_b,
  output logic                 shdn_a,
  output logic                 shdn_b,
  output logic                 update,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [7:0]           frame_count
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam int unsigned IN_W  = DATA_BITS + 2;
  localparam logic [IN_W-1:0] IN_RST = {2'b11, {DATA_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0] r_csn_sync, r_sclk_sync, r_mosi_sync, r_latchn_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_csn_prev, r_sclk_prev, r_mosi_prev, r_latchn_prev;
  logic                   r_csn_fall, r_csn_rise, r_sclk_rise, r_latch_fall;
  logic                   r_csn_armed, r_latch_armed;
  logic                   w_csn_s, w_sclk_s, w_mosi_s, w_latchn_s, w_filled;
  logic                   w_csn_fall, w_latch;

  state_t                 r_state, w_state_nxt;
  logic                   w_clear, w_shift, w_commit;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;

  logic                   w_commit_ok, w_commit_err, w_sel_b;
  logic [IN_W-1:0]        w_new, w_fwd_a, w_fwd_b;
  logic [IN_W-1:0]        r_in_a, r_in_b, r_out_a, r_out_b;
  logic                   r_update, r_frame_valid, r_frame_err;
  logic [7:0]             r_frame_count;

  assign w_csn_s    = r_csn_sync[SYNC_STAGES-1];
  assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_latchn_s = r_latchn_sync[SYNC_STAGES-1];
  assign w_filled   = r_fill[SYNC_STAGES-1];

  // Edges are registered so that mosi (via r_mosi_prev) lines up with r_sclk_rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csn_sync    <= '1;
      r_latchn_sync <= '1;
      r_sclk_sync   <= '0;
      r_mosi_sync   <= '0;
      r_fill        <= '0;
      r_csn_prev    <= 1'b1;
      r_latchn_prev <= 1'b1;
      r_sclk_prev   <= 1'b0;
      r_mosi_prev   <= 1'b0;
      r_csn_fall    <= 1'b0;
      r_csn_rise    <= 1'b0;
      r_sclk_rise   <= 1'b0;
      r_latch_fall  <= 1'b0;
      r_csn_armed   <= 1'b0;
      r_latch_armed <= 1'b0;
    end else begin
      r_csn_sync    <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
      r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_latchn_sync <= {r_latchn_sync[SYNC_STAGES-2:0], spi_latchn};
      r_fill        <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_csn_prev    <= w_csn_s;
      r_sclk_prev   <= w_sclk_s;
      r_mosi_prev   <= w_mosi_s;
      r_latchn_prev <= w_latchn_s;
      r_csn_fall    <= r_csn_prev & ~w_csn_s;
      r_csn_rise    <= ~r_csn_prev & w_csn_s;
      r_sclk_rise   <= ~r_sclk_prev & w_sclk_s;
      r_latch_fall  <= r_latchn_prev & ~w_latchn_s;
      // Only a genuinely sampled high level arms falling-edge detection after reset.
      r_csn_armed   <= r_csn_armed | (w_filled & w_csn_s);
      r_latch_armed <= r_latch_armed | (w_filled & w_latchn_s);
    end
  end

  assign w_csn_fall = r_csn_fall & r_csn_armed;
  assign w_latch    = r_latch_fall & r_latch_armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_csn_fall) begin
          w_state_nxt = S_SHIFT;
          w_clear     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_csn_fall) begin
          w_clear = 1'b1;
        end else begin
          w_shift = r_sclk_rise;
          if (r_csn_rise) w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        if (w_csn_fall) begin
          w_state_nxt = S_SHIFT;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], r_mosi_prev};
      if (r_bit_cnt != CNT_W'(FRAME_BITS + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign w_commit_ok  = w_commit && (r_bit_cnt == CNT_W'(FRAME_BITS));
  assign w_commit_err = w_commit && !w_commit_ok;
  assign w_sel_b      = r_shift[FRAME_BITS-1];
  assign w_new        = {r_shift[FRAME_BITS-3], ~r_shift[FRAME_BITS-4], r_shift[DATA_BITS-1:0]};
  // A latch coinciding with a commit forwards the frame being committed.
  assign w_fwd_a      = (w_commit_ok && !w_sel_b) ? w_new : r_in_a;
  assign w_fwd_b      = (w_commit_ok &&  w_sel_b) ? w_new : r_in_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_a        <= IN_RST;
      r_in_b        <= IN_RST;
      r_out_a       <= IN_RST;
      r_out_b       <= IN_RST;
      r_update      <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_update      <= w_latch;
      r_frame_valid <= w_commit_ok;
      r_frame_err   <= w_commit_err;
      if (w_commit_ok) begin
        r_in_a        <= w_fwd_a;
        r_in_b        <= w_fwd_b;
        r_frame_count <= r_frame_count + 8'd1;
      end
      if (w_latch) begin
        r_out_a <= w_fwd_a;
        r_out_b <= w_fwd_b;
      end
    end
  end

  assign dac_a       = r_out_a[DATA_BITS-1:0];
  assign dac_b       = r_out_b[DATA_BITS-1:0];
  assign shdn_a      = r_out_a[DATA_BITS];
  assign shdn_b      = r_out_b[DATA_BITS];
  assign gain_a      = r_out_a[DATA_BITS+1];
  assign gain_b      = r_out_b[DATA_BITS+1];
  assign update      = r_update;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed bench for dac_spi_receiver: SPI frames, latch strobes and reset cases
// with hand-computed expected register contents.
module tb_dac_spi_receiver;

  localparam int HALF = 2;

  logic        clk = 1'b0;
  logic        reset_n, spi_csn, spi_sclk, spi_mosi, spi_latchn;
  logic [11:0] dac_a, dac_b;
  logic        gain_a, gain_b, shdn_a, shdn_b;
  logic        update, frame_valid, frame_err;
  logic [7:0]  frame_count;

  int n_checks = 0;
  int n_errors = 0;

  int          m_fv_cnt, m_fv_at, m_err_cnt, m_upd_cnt;
  logic [11:0] m_a_pre, m_b_pre;
  int          fv_total;

  always #5 clk = ~clk;

  dac_spi_receiver #(
    .FRAME_BITS (16),
    .DATA_BITS  (12),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_csn    (spi_csn),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_latchn (spi_latchn),
    .dac_a      (dac_a),
    .dac_b      (dac_b),
    .gain_a     (gain_a),
    .gain_b     (gain_b),
    .shdn_a     (shdn_a),
    .shdn_b     (shdn_b),
    .update     (update),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observes ncyc rising edges; cycle 0 is the first edge after the call.
  task automatic watch(input int ncyc);
    logic [11:0] pa, pb;
    m_fv_cnt  = 0;
    m_fv_at   = -1;
    m_err_cnt = 0;
    m_upd_cnt = 0;
    m_a_pre   = '0;
    m_b_pre   = '0;
    for (int c = 0; c < ncyc; c++) begin
      pa = dac_a;
      pb = dac_b;
      @(posedge clk);
      #1;
      if (frame_valid) begin
        m_fv_cnt++;
        if (m_fv_at < 0) m_fv_at = c;
      end
      if (frame_err) m_err_cnt++;
      if (update) begin
        m_upd_cnt++;
        m_a_pre = pa;
        m_b_pre = pb;
      end
    end
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
  endtask

  task automatic do_latch();
    @(negedge clk);
    spi_latchn = 1'b0;
    watch(8);
    @(negedge clk);
    spi_latchn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " dac_a"}, 32'(dac_a), 32'h0);
    check({tag, " dac_b"}, 32'(dac_b), 32'h0);
    check({tag, " gain"}, 32'({gain_a, gain_b}), 32'h3);
    check({tag, " shdn"}, 32'({shdn_a, shdn_b}), 32'h3);
    check({tag, " pulses"}, 32'({update, frame_valid, frame_err}), 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    spi_csn    = 1'b1;
    spi_sclk   = 1'b0;
    spi_mosi   = 1'b0;
    spi_latchn = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    check("por count", 32'(frame_count), 32'h0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Channel A load: 0x3ABC -> A, gain 1x, active, code 0xABC
    send_bits(32'h3ABC, 16);
    watch(8);
    check("chA fv latency", 32'(m_fv_at), 32'd4);
    check("chA fv pulses", 32'(m_fv_cnt), 32'd1);
    check("chA err", 32'(m_err_cnt), 32'd0);
    check("chA no update", 32'(m_upd_cnt), 32'd0);
    check("chA count", 32'(frame_count), 32'd1);
    check("chA dac_a buffered", 32'(dac_a), 32'h0);
    do_latch();
    check("chA upd pulses", 32'(m_upd_cnt), 32'd1);
    check("chA dac_a", 32'(dac_a), 32'hABC);
    check("chA gain_a", 32'(gain_a), 32'h1);
    check("chA shdn_a", 32'(shdn_a), 32'h0);
    check("chA dac_b", 32'(dac_b), 32'h0);

    // Reset mid-run, then double buffering
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst mid");
    check("rst mid count", 32'(frame_count), 32'h0);
    reset_n = 1'b1;
    watch(8);
    check("rst rel pulses", 32'(m_fv_cnt + m_err_cnt + m_upd_cnt), 32'd0);
    check("rst rel dac_a", 32'(dac_a), 32'h0);
    check("rst rel gain_a", 32'(gain_a), 32'h1);

    send_bits(32'hB123, 16);
    watch(8);
    check("dbl B123 fv", 32'(m_fv_cnt), 32'd1);
    send_bits(32'h0456, 16);
    watch(8);
    check("dbl 0456 fv", 32'(m_fv_cnt), 32'd1);
    check("dbl pre dac_a", 32'(dac_a), 32'h0);
    check("dbl pre dac_b", 32'(dac_b), 32'h0);
    check("dbl count", 32'(frame_count), 32'd2);
    do_latch();
    check("dbl upd pulses", 32'(m_upd_cnt), 32'd1);
    check("dbl dac_a", 32'(dac_a), 32'h456);
    check("dbl gain_a", 32'(gain_a), 32'h0);
    check("dbl shdn_a", 32'(shdn_a), 32'h1);
    check("dbl dac_b", 32'(dac_b), 32'h123);
    check("dbl gain_b", 32'(gain_b), 32'h1);
    check("dbl shdn_b", 32'(shdn_b), 32'h0);
    check("dbl same-cycle pre", 32'({m_a_pre, m_b_pre}), 32'h0);

    // Bit-count errors: 15 and 17 bits
    send_bits(32'h3ABC, 15);
    watch(8);
    check("err15 err", 32'(m_err_cnt), 32'd1);
    check("err15 fv", 32'(m_fv_cnt), 32'd0);
    send_bits(32'h13ABC, 17);
    watch(8);
    check("err17 err", 32'(m_err_cnt), 32'd1);
    check("err17 fv", 32'(m_fv_cnt), 32'd0);
    check("err count", 32'(frame_count), 32'd2);
    do_latch();
    check("err latch dac_a", 32'(dac_a), 32'h456);
    check("err latch gain_a", 32'(gain_a), 32'h0);
    check("err latch dac_b", 32'(dac_b), 32'h123);
    check("err latch shdn_b", 32'(shdn_b), 32'h0);

    // Commit/latch collision: latchn falls one clk after csn rises
    send_bits(32'h3FFF, 16);
    fork
      watch(10);
      begin
        @(negedge clk);
        spi_latchn = 1'b0;
      end
    join
    @(negedge clk);
    spi_latchn = 1'b1;
    repeat (4) @(negedge clk);
    check("coll fv latency", 32'(m_fv_at), 32'd4);
    check("coll upd pulses", 32'(m_upd_cnt), 32'd1);
    check("coll dac_a", 32'(dac_a), 32'hFFF);
    check("coll gain_a", 32'(gain_a), 32'h1);
    check("coll shdn_a", 32'(shdn_a), 32'h0);
    check("coll dac_b", 32'(dac_b), 32'h123);
    check("coll count", 32'(frame_count), 32'd3);

    // frame_count wrap
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    fv_total = 0;
    for (int i = 0; i < 256; i++) begin
      send_bits(32'h3000 | 32'(i), 16);
      watch(8);
      fv_total += m_fv_cnt;
      if (i == 254) check("wrap count 255", 32'(frame_count), 32'd255);
    end
    check("wrap fv total", 32'(fv_total), 32'd256);
    check("wrap count 0", 32'(frame_count), 32'd0);
    do_latch();
    check("wrap dac_a", 32'(dac_a), 32'h0FF);
    check("wrap gain_a", 32'(gain_a), 32'h1);
    check("wrap shdn_a", 32'(shdn_a), 32'h0);

    // Reset mid-frame, release with csn still low
    @(negedge clk);
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    spi_mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst frame");
    reset_n = 1'b1;
    watch(16);
    check("rst csn-low pulses", 32'(m_fv_cnt + m_err_cnt + m_upd_cnt), 32'd0);
    @(negedge clk);
    spi_csn = 1'b1;
    watch(8);
    check("rst csn-rise fv", 32'(m_fv_cnt), 32'd0);
    check("rst csn-rise err", 32'(m_err_cnt), 32'd0);
    send_bits(32'h3ABC, 16);
    watch(8);
    check("rst fresh fv latency", 32'(m_fv_at), 32'd4);
    check("rst fresh count", 32'(frame_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_spi_receiver.md
Name: dac_spi_receiver

Overview:
- SPI responder for the laser-galvo DAC link: the other end of the mapped-IO SPI master (dac_csn/dac_sclk/dac_mosi) plus dac_latchn.
- Oversamples the SPI pins in the system clock domain and decodes 16-bit dual-channel DAC frames into per-channel input registers.
- Transfers the input registers to output registers on a latch strobe, modelling a double-buffered 12-bit DAC.
- Used as the in-fabric DAC model for bench and loopback checking of laser beta firmware, and as a debug tap driving debug_led.

Parameters:
FRAME_BITS, 16, bits per valid frame
DATA_BITS, 12, DAC code width (frame bits DATA_BITS-1:0)
SYNC_STAGES, 2, synchroniser flops on each SPI input (minimum 2)

Ports:
clk  input  1  system clock; must run at least 4x the sclk frequency
reset_n  input  1  asynchronous active-low reset
spi_csn  input  1  chip select, active low, asynchronous to clk
spi_sclk  input  1  serial clock, idle low, data sampled on the rising edge
spi_mosi  input  1  serial data, MSB first
spi_latchn  input  1  DAC latch strobe, active on the falling edge
dac_a  output  DATA_BITS  latched channel A code
dac_b  output  DATA_BITS  latched channel B code
gain_a, gain_b  output  1  latched gain select (frame bit 13: 1 = 1x, 0 = 2x)
shdn_a, shdn_b  output  1  latched shutdown flag (set when frame bit 12 = 0)
update  output  1  one-cycle pulse when the output registers load
frame_valid  output  1  one-cycle pulse when a 16-bit frame commits
frame_err  output  1  one-cycle pulse when a frame is discarded
frame_count  output  8  count of committed frames, wraps 255 -> 0

Behaviour:
- Reset: all outputs 0, except gain_a/gain_b = 1 and shdn_a/shdn_b = 1. Input registers, shift register, bit counter and sync flops clear. The sync flops for csn and latchn reset to 1; those for sclk and mosi reset to 0.
- Each SPI input passes through SYNC_STAGES flops, then one "previous" flop for edge detection. Edges are evaluated on the synchronised values only.
- FSM states:
  - IDLE: on a csn falling edge -> SHIFT. Clear the bit counter and the shift register.
  - SHIFT: each sclk rising edge shifts mosi into the LSB and increments the bit counter (saturating at FRAME_BITS+1). On a csn rising edge -> COMMIT.
  - COMMIT (one cycle): if the counter equals FRAME_BITS, the frame is valid. Otherwise pulse frame_err. Return to IDLE.
- sclk edges while in IDLE are ignored. A csn falling edge while in SHIFT restarts the frame (counter cleared) and does not pulse frame_err.
- Valid frame decode:
  - bit 15 selects the channel (0 = A, 1 = B); bit 14 (BUF) is ignored.
  - bit 13 is the gain bit; bit 12 is the SHDNn bit; bits 11:0 are the data.
  - The selected channel's input register {gain, shdn = ~bit12, data} loads.
  - frame_valid pulses and frame_count increments in the COMMIT cycle.
- Latency: the input register and frame_valid are updated exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples the raw csn rising edge.
- Latch:
  - A synchronised latchn falling edge copies both input registers to the outputs on the next clk edge and pulses update.
  - A latchn falling edge while csn is low (mid-frame) is still honoured; the frame in progress is unaffected.
- Simultaneous events: if the latch transfer and COMMIT occur in the same cycle, the output registers take the newly committed value (commit-then-latch forwarding).
- Overrun: more than FRAME_BITS sclk edges yields frame_err at COMMIT. Input registers stay unchanged.
- Asynchronous reset mid-frame: the frame is abandoned with no pulses. After release, the block waits in IDLE for a fresh csn falling edge, even if csn is already low.

Test Plan:
- Reset values: assert reset_n = 0 mid-run -> dac_a = dac_b = 0, gain_a = gain_b = 1, shdn_a = shdn_b = 1, no pulses; release -> all outputs hold.
- Channel A load: frame 0x3ABC (A, gain 1x, active, code 0xABC), then a latchn falling edge -> frame_valid exactly 4 clks after the csn rise is first sampled; dac_a = 0xABC, gain_a = 1, shdn_a = 0; update pulses once; dac_b unchanged.
- Double buffering: frames 0xB123 then 0x0456 with no latch -> dac_a and dac_b still 0. One latchn falling edge -> dac_a = 0x456, gain_a = 0, shdn_a = 1; dac_b = 0x123, gain_b = 1, shdn_b = 0; both change in the same cycle.
- Bit-count errors: 15-bit frame and 17-bit frame -> frame_err pulses twice, frame_valid never pulses, frame_count unchanged, input registers unchanged (verified via a subsequent latch).
- Commit/latch collision: drive the latchn falling edge so its synchronised edge lands in the COMMIT cycle of frame 0x3FFF -> dac_a = 0xFFF on that update.
- Wrap and reset mid-frame: 256 valid frames -> frame_count returns to 0. Assert reset_n after 8 sclk edges -> no pulses. After release with csn still low, the next 16 clocks -> no commit until csn goes high then low.
